// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq: drives an SPI master's register port to perform a
// serial-flash READ (0x03 + 24-bit address + len dummy bytes). The data-phase
// rx bytes are collected in a small FIFO exposed as a valid/ready byte stream.
module spi_flash_rd_seq #(
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  CLK_DIV    = 8'd0,
  parameter logic        CPOL       = 1'b0,
  parameter logic        CPHA       = 1'b0,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [23:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic [31:0]      m_addr_o,
  output logic [31:0]      m_data_o,
  output logic             m_we_o,
  output logic [3:0]       m_sel_o,
  input  logic [31:0]      m_data_i
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = LEN_W + 3;  // holds 4 header bytes + len without wrap

  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_DATA = 32'h4;
  localparam logic [31:0] A_STAT = 32'h8;

  typedef enum logic [3:0] {
    S_IDLE, S_SEL, S_LOAD, S_GO, S_WAIT, S_POLL, S_RD, S_DESEL, S_FIN
  } state_t;

  state_t           r_state, w_nxt;
  logic [23:0]      r_addr;
  logic [LEN_W-1:0] r_len;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_to;
  logic             r_err;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_level;

  logic             w_accept, w_to_hit, w_to_clr, w_cnt_inc, w_push, w_pop;
  logic             w_data_byte, w_last, w_full;
  logic [7:0]       w_tx;
  logic             w_unused;

  function automatic logic [31:0] ctrl_word(input logic ss, input logic go);
    return {16'h0, CLK_DIV, 4'h0, ss, CPHA, CPOL, go};
  endfunction

  assign w_data_byte = (r_cnt >= CW'(4));
  assign w_last      = (r_cnt == (CW'(r_len) + CW'(3)));
  assign w_full      = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_pop       = rx_valid_o && rx_ready_i;
  assign w_unused    = ^m_data_i[31:8];

  assign rx_valid_o  = (r_level != '0);
  assign rx_data_o   = r_mem[r_rp];
  assign err_o       = r_err;
  assign busy_o      = (r_state != S_IDLE) && (r_state != S_FIN);
  assign m_sel_o     = m_we_o ? 4'hF : 4'h0;

  // Outgoing MOSI byte for the current position in the stream
  always_comb begin
    w_tx = 8'h00;
    if (r_cnt == CW'(0))      w_tx = 8'h03;
    else if (r_cnt == CW'(1)) w_tx = r_addr[23:16];
    else if (r_cnt == CW'(2)) w_tx = r_addr[15:8];
    else if (r_cnt == CW'(3)) w_tx = r_addr[7:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  // Next-state and bus-port decode
  always_comb begin
    w_nxt     = r_state;
    m_addr_o  = 32'h0;
    m_data_o  = 32'h0;
    m_we_o    = 1'b0;
    done_o    = 1'b0;
    w_accept  = 1'b0;
    w_to_hit  = 1'b0;
    w_to_clr  = 1'b0;
    w_cnt_inc = 1'b0;
    w_push    = 1'b0;
    case (r_state)
      S_IDLE, S_FIN: begin
        // FIN is already not busy, so it accepts a start just like IDLE
        if (r_state == S_FIN) begin
          done_o = 1'b1;
          w_nxt  = S_IDLE;
        end
        if (start_i) begin
          if (len_i == '0) begin
            w_nxt = S_FIN;
          end else begin
            w_accept = 1'b1;
            w_nxt    = S_SEL;
          end
        end
      end
      S_SEL: begin
        m_addr_o = A_CTRL;
        m_data_o = ctrl_word(1'b1, 1'b0);
        m_we_o   = 1'b1;
        w_nxt    = S_LOAD;
      end
      S_LOAD: begin
        // A data byte only goes out once its FIFO slot is guaranteed
        if (!(w_data_byte && w_full)) begin
          m_addr_o = A_DATA;
          m_data_o = {24'h0, w_tx};
          m_we_o   = 1'b1;
          w_nxt    = S_GO;
        end
      end
      S_GO: begin
        m_addr_o = A_CTRL;
        m_data_o = ctrl_word(1'b1, 1'b1);
        m_we_o   = 1'b1;
        w_nxt    = S_WAIT;
      end
      S_WAIT: begin
        m_addr_o = A_STAT;
        w_to_clr = 1'b1;
        w_nxt    = S_POLL;
      end
      S_POLL: begin
        m_addr_o = A_STAT;
        if (!m_data_i[0]) begin
          w_nxt = S_RD;
        end else if (r_to == (TIMEOUT - 16'd1)) begin
          w_to_hit = 1'b1;
          w_nxt    = S_DESEL;
        end
      end
      S_RD: begin
        m_addr_o  = A_DATA;
        w_push    = w_data_byte;
        w_cnt_inc = 1'b1;
        w_nxt     = w_last ? S_DESEL : S_LOAD;
      end
      S_DESEL: begin
        m_addr_o = A_CTRL;
        m_data_o = ctrl_word(1'b0, 1'b0);
        m_we_o   = 1'b1;
        w_nxt    = S_FIN;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Operation context: address/length latch, byte counter, poll timer, error flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_to   <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= addr_i;
        r_len  <= len_i;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end
      if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
      if (w_to_clr)                   r_to <= '0;
      else if (r_state == S_POLL)     r_to <= r_to + 16'd1;
      if (w_to_hit) r_err <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop both take effect
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= m_data_i[7:0];
  end

endmodule

// File: doc/spi_flash_rd_seq.md
Name: spi_flash_rd_seq

Overview:
- Bus-master sequencer that drives the SPI master peripheral's register port directly upstream of it.
- Runs a complete serial-flash READ (opcode 0x03): asserts slave select, sends opcode + 24-bit address, clocks out `len` dummy bytes and captures the returned bytes.
- Returned bytes go into a small FIFO exposed as a valid/ready byte stream, so DMA or boot-copy logic can pull flash contents without CPU polling.

Parameters:
- LEN_W, 16: width of the byte-count input.
- FIFO_DEPTH, 4: rx FIFO entries; power of two, ≥2.
- CLK_DIV, 8'd0: value written to SPI ctrl[15:8] (0 = clk/2, 1 = clk/4, ...).
- CPOL, 1'b0: value written to ctrl[1].
- CPHA, 1'b0: value written to ctrl[2].
- TIMEOUT, 16'hFFFF: maximum status-poll cycles per byte before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start_i  in  1  one-cycle pulse; launch a read (ignored while busy_o=1).
- addr_i  in  24  flash byte address; sampled on an accepted start_i.
- len_i  in  LEN_W  number of data bytes; sampled on an accepted start_i.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse at end of operation (normal or aborted).
- err_o  out  1  sticky timeout flag; cleared by the next accepted start.
- rx_data_o  out  8  FIFO head byte.
- rx_valid_o  out  1  FIFO non-empty.
- rx_ready_i  in  1  consumer pop; a pop occurs when valid and ready are both high.
- m_addr_o  out  32  SPI register address: 0x0 ctrl, 0x4 data, 0x8 status.
- m_data_o  out  32  SPI write data.
- m_we_o  out  1  SPI write strobe; one cycle per write.
- m_sel_o  out  4  byte enables; 4'hF on every write, 4'h0 otherwise.
- m_data_i  in  32  SPI read data; combinational from m_addr_o.

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM → IDLE; FIFO emptied.
  - busy_o, done_o, err_o, rx_valid_o, m_we_o = 0; m_sel_o = 0; m_addr_o = 0; m_data_o = 0.
  - Reset mid-operation aborts with no deselect write; the SPI peripheral shares rst, so it also returns to idle.
- Ctrl word: CTRL(ss, go) = {16'h0, CLK_DIV, 4'h0, ss, CPHA, CPOL, go}.
- Byte stream per operation: 0x03, A[23:16], A[15:8], A[7:0], then len_i bytes of 0x00. Rx bytes are kept only for the data bytes; header rx bytes are discarded.
- FSM states:
  - IDLE: wait for start_i. If len_i==0: pulse done_o next cycle, no bus writes, busy_o stays 0. Otherwise latch addr/len, clear err_o, go to SEL.
  - SEL: write CTRL(1,0) to 0x0 (assert slave select). Go to LOAD.
  - LOAD: for a data byte, stay in LOAD with m_we_o=0 while the FIFO is full (slot reservation; the FIFO can never overflow). Otherwise write the byte to 0x4 and go to GO.
  - GO: write CTRL(1,1) to 0x0. Go to WAIT.
  - WAIT: one idle cycle (m_addr_o=0x8, no write) covering the peripheral's start latency. Go to POLL.
  - POLL: m_addr_o=0x8; exit when m_data_i[0]==0. Each cycle in POLL increments the timeout counter.
    - Counter == TIMEOUT-1 while still busy → set err_o, go to DESEL.
  - RD: m_addr_o=0x4. For data bytes, push m_data_i[7:0]. Increment the byte counter. If the last byte is done go to DESEL, else LOAD.
  - DESEL: write CTRL(0,0) to 0x0. Go to FIN.
  - FIN: pulse done_o, drop busy_o, go to IDLE.
- Push and pop in the same cycle are both performed. With a full FIFO, pop-then-push is legal.
- The FIFO survives across operations. It is not flushed on start; only reset clears it.
- The byte counter is LEN_W+3 bits, so it holds 4 + len without wrap. len = 2^LEN_W - 1 must work.
- start_i while busy_o=1 is ignored, with no effect on addr, len or err_o.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release → all outputs 0, no m_we_o for 5 idle cycles.
- Basic read: addr=0x012345, len=2; slave model returns 0xA5, 0x3C in the data phase → MOSI bytes 03 01 23 45 00 00; FIFO yields A5 then 3C; exactly one done_o; ss asserted throughout, deasserted after.
- Backpressure: len=6, FIFO_DEPTH=4, rx_ready_i=0 until done is blocked → sequencer stalls in LEN/LOAD after 4 bytes. Raise rx_ready_i → all 6 bytes arrive in order, no loss or duplicate.
- len=0: start_i → done_o the next cycle, no bus writes, busy_o never high.
- Timeout: TIMEOUT=16, status bit0 forced to 1 → err_o=1, DESEL write CTRL(0,0) issued, done_o pulses. A new start clears err_o.
- Stray start and reset: start_i pulse mid-operation → ignored. rst=0 mid data phase → FIFO empty, FSM idle, a fresh read succeeds.
